// File: rtl/pipe_pkg.sv
// Shared constants for the elastic inter-stage pipeline register.
// State encoding and default widths used by pipe_stage_reg and its counters.
package pipe_pkg;

    typedef logic [1:0] pipe_state_t;

    localparam pipe_state_t ST_EMPTY = 2'd0;
    localparam pipe_state_t ST_FULL  = 2'd1;
    localparam pipe_state_t ST_SKID  = 2'd2;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 32;
    localparam int DEF_BYP_W  = 32;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones once reached so long-running stalls never wrap.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!nreset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: main register plus one skid entry, registered in_ready,
// flush-to-bubble, and a combinational bypass. PIPE_STAGE_PERF_CNT_EN adds stall/bubble counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                CTRL_W   = DEF_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{1'b0}},
    parameter int                BYP_W    = DEF_BYP_W,
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic [BYP_W-1:0]  byp_in,
    output logic [BYP_W-1:0]  byp_out,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_t       state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Squash: same-cycle input is dropped, registers return to bubble.
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = CTRL_RST;
            skid_data_d = '0;
            skid_ctrl_d = CTRL_RST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && in_valid) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (out_ready) begin
                        // Data is left in place; only control must read as a bubble.
                        main_ctrl_d = CTRL_RST;
                        state_d     = ST_EMPTY;
                    end else if (in_valid) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_ready) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ST_FULL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = CTRL_RST;
                end
            endcase
        end

        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= '0;
            main_ctrl_q <= CTRL_RST;
            skid_data_q <= '0;
            skid_ctrl_q <= CTRL_RST;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == ST_FULL) || (state_q == ST_SKID);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign byp_out   = byp_in;

    always_ff @(posedge clock) begin
        if (nreset)
            assert (out_valid || (out_ctrl == CTRL_RST));
    end

`ifdef PIPE_STAGE_PERF_CNT_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock  (clock),
        .nreset (nreset),
        .inc    (out_valid && !out_ready),
        .count  (stall_cnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clock  (clock),
        .nreset (nreset),
        .inc    (!out_valid),
        .count  (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector bench for pipe_stage_reg: reset, streaming, skid, flush, drain bubble, counters.
module tb_pipe_stage_reg;

    localparam int          DATA_W = 32;
    localparam int          CTRL_W = 32;
    localparam int          BYP_W  = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_C  = 32'h0000_A5A5;

    logic              clock = 1'b0;
    logic              nreset, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [BYP_W-1:0]  byp_in, byp_out;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .CTRL_RST (RST_C),
        .BYP_W    (BYP_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .byp_in     (byp_in),
        .byp_out    (byp_out),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
    endtask

    logic [31:0] exp_stall, exp_bubble;

    initial begin
        nreset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 32'h11;
        byp_in = 32'h1234_5678;

        // Reset held two cycles with valid input present
        cyc(); cyc();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_out_ctrl",  out_ctrl, RST_C);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_byp",       byp_out,  32'h1234_5678);
        chk("rst_stall",     {28'b0, stall_cnt},  32'd0);
        chk("rst_bubble",    {28'b0, bubble_cnt}, 32'd0);

        nreset = 1'b1; in_valid = 1'b0;
        cyc();
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // Streaming 1..8 with out_ready high: 1-cycle latency, no gaps
        for (int i = 1; i <= 8; i++) begin
            send(i, 32'h100 + i);
            cyc();
            chk("strm_valid", {31'b0, out_valid}, 32'd1);
            chk("strm_data",  out_data, i);
            chk("strm_ctrl",  out_ctrl, 32'h100 + i);
            chk("strm_ready", {31'b0, in_ready}, 32'd1);
        end

        // Drain bubble: ctrl goes to reset pattern, data holds
        send(32'h9, 32'h55);
        cyc();
        chk("drn_ctrl_pre", out_ctrl, 32'h55);
        in_valid = 1'b0;
        cyc();
        chk("drn_valid", {31'b0, out_valid}, 32'd0);
        chk("drn_ctrl",  out_ctrl, RST_C);
        chk("drn_data",  out_data, 32'h9);

        // Stall into skid
        out_ready = 1'b0;
        send(32'hA, 32'h0A);
        cyc();
        chk("stl_a_data",  out_data, 32'hA);
        chk("stl_a_ready", {31'b0, in_ready}, 32'd1);
        send(32'hB, 32'h0B);
        cyc();
        chk("skid_ready", {31'b0, in_ready}, 32'd0);
        chk("skid_valid", {31'b0, out_valid}, 32'd1);
        chk("skid_data",  out_data, 32'hA);
        // Offered but never accepted: in_ready is low
        send(32'hEE, 32'hEE);
        cyc();
        chk("skid_hold_data",  out_data, 32'hA);
        chk("skid_hold_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        cyc();
        chk("skid_drn_data",  out_data, 32'hB);
        chk("skid_drn_ctrl",  out_ctrl, 32'h0B);
        chk("skid_drn_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        cyc();
        chk("skid_end_valid", {31'b0, out_valid}, 32'd0);
        chk("skid_end_data",  out_data, 32'hB);

        // Flush while in SKID with a concurrent input offer
        out_ready = 1'b0;
        send(32'h10, 32'h10); cyc();
        send(32'h11, 32'h11); cyc();
        chk("fl_pre_ready", {31'b0, in_ready}, 32'd0);
        send(32'hC, 32'h0C);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ctrl",  out_ctrl, RST_C);
        chk("fl_data",  out_data, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        cyc();
        chk("fl_after_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_after_data",  out_data, 32'd0);

        // Flush discards a same-cycle input accepted from EMPTY
        send(32'h33, 32'h33);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_empty_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_empty_ctrl",  out_ctrl, RST_C);

        byp_in = 32'hCAFE_F00D;
        #1;
        chk("byp_live", byp_out, 32'hCAFE_F00D);

        // Counters: reset, 3 bubbles, load, 20 stalls, flush
        nreset = 1'b0; cyc(); nreset = 1'b1;
        cyc(); cyc(); cyc();
`ifdef PIPE_STAGE_PERF_CNT_EN
        exp_bubble = 32'd3; exp_stall = 32'd0;
`else
        exp_bubble = 32'd0; exp_stall = 32'd0;
`endif
        chk("cnt_bubble3", {28'b0, bubble_cnt}, exp_bubble);
        chk("cnt_stall0",  {28'b0, stall_cnt},  exp_stall);
        out_ready = 1'b0;
        send(32'h5, 32'h5);
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
`ifdef PIPE_STAGE_PERF_CNT_EN
        exp_bubble = 32'd4; exp_stall = 32'hF;
`endif
        chk("cnt_stall_sat", {28'b0, stall_cnt},  exp_stall);
        chk("cnt_bubble4",   {28'b0, bubble_cnt}, exp_bubble);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("cnt_fl_stall",  {28'b0, stall_cnt},  exp_stall);
        chk("cnt_fl_bubble", {28'b0, bubble_cnt}, exp_bubble);
        nreset = 1'b0; cyc(); nreset = 1'b1;
        chk("cnt_rst_stall",  {28'b0, stall_cnt},  32'd0);
        chk("cnt_rst_bubble", {28'b0, bubble_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
